mult_pool_alloc: RTL and testbench

- Central allocator for the shared multiplier pool used by the convolution controllers.
- Holds the pool occupancy bitmap and takes multiplier-count requests from up to NREQ conv controllers. Requesters are served round-robin.
- For each served request it claims the lowest-index free multipliers, returns them as a one-hot-per-multiplier grant mask, and frees multipliers when owners release them.
- Replaces ad-hoc occupancy scanning inside each conv FSM.

---
 rtl/mult_pool_alloc_pkg.sv | 26 ++
 rtl/mult_pool_alloc_if.sv | 27 ++
 rtl/mult_pool_alloc_rr_pick.sv | 27 ++
 rtl/mult_pool_alloc.sv | 154 +++++++++++++++
 tb/tb_mult_pool_alloc.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_pool_alloc_pkg.sv
// Shared types and helpers for the multiplier-pool allocator.
package mult_pool_pkg;

  localparam int unsigned NMULT_DEF = 64;
  localparam int unsigned NREQ_DEF  = 4;
  localparam int unsigned SCANW_DEF = 8;
  localparam int unsigned POPW      = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    SCAN  = 2'd2,
    GRANT = 2'd3
  } state_t;

  // Callers zero-extend narrower vectors to POPW before counting.
  function automatic int unsigned popcount(input logic [POPW-1:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < POPW; i++) begin
      n = n + 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/mult_pool_alloc_if.sv
// Request/grant/release bus between conv controllers and the pool allocator.
interface mult_pool_alloc_if #(
  parameter int unsigned NMULT = 64,
  parameter int unsigned NREQ  = 4,
  parameter int unsigned RIDW  = 2,
  parameter int unsigned CNTW  = 7
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*CNTW-1:0] req_cnt;
  logic                 gnt_valid;
  logic [RIDW-1:0]      gnt_id;
  logic [NMULT-1:0]     gnt_mask;
  logic                 gnt_err;
  logic                 gnt_ack;
  logic                 rel_valid;
  logic [NMULT-1:0]     rel_mask;

  modport master (
    output req_valid, req_cnt, gnt_ack, rel_valid, rel_mask,
    input  gnt_valid, gnt_id, gnt_mask, gnt_err
  );

  modport slave (
    input  req_valid, req_cnt, gnt_ack, rel_valid, rel_mask,
    output gnt_valid, gnt_id, gnt_mask, gnt_err
  );
endinterface

// File: rtl/mult_pool_alloc_rr_pick.sv
// Combinational round-robin picker: first eligible index at or after ptr, wrapping.
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned RIDW = 2
) (
  input  logic [NREQ-1:0] elig,
  input  logic [RIDW-1:0] ptr,
  output logic            found,
  output logic [RIDW-1:0] idx
);

  logic [RIDW-1:0] j;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      j = RIDW'((32'(ptr) + k) % NREQ);
      if (!found && elig[j]) begin
        found = 1'b1;
        idx   = j;
      end
    end
  end

endmodule

// File: rtl/mult_pool_alloc.sv
// Multiplier pool allocator: round-robin arbitration, windowed lowest-free claim,
// one-hot grant mask, and owner-driven release.
module mult_pool_alloc
  import mult_pool_pkg::*;
#(
  parameter int unsigned NMULT = NMULT_DEF,
  parameter int unsigned NREQ  = NREQ_DEF,
  parameter int unsigned RIDW  = 2,
  parameter int unsigned CNTW  = 7,
  parameter int unsigned SCANW = SCANW_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  mult_pool_alloc_if.slave bus,
  output logic [NMULT-1:0] occ_map,
  output logic [CNTW-1:0]  free_cnt,
  output logic             busy
);

  localparam int unsigned     IDXW     = $clog2(NMULT);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NMULT - SCANW);
  localparam logic [CNTW-1:0] MAXCNT   = CNTW'(NMULT);

  state_t           state;
  logic [NMULT-1:0] occ;
  logic [NMULT-1:0] pend;
  logic [RIDW-1:0]  rr_ptr;
  logic [RIDW-1:0]  sel_id;
  logic [CNTW-1:0]  remaining;
  logic [IDXW-1:0]  scan_idx;

  logic [POPW-1:0]  occ_ext;
  logic [NREQ-1:0]  elig;
  logic [CNTW-1:0]  cnt_r;
  logic             pick_found;
  logic [RIDW-1:0]  pick_idx;
  logic [CNTW-1:0]  pick_cnt;
  logic             pick_err;
  logic [SCANW-1:0] win;
  logic [SCANW-1:0] claim;
  logic [CNTW-1:0]  left;
  logic [NMULT-1:0] claim_full;
  logic [NMULT-1:0] rel_eff;

  assign occ_ext  = POPW'(occ);
  assign free_cnt = CNTW'(NMULT - popcount(occ_ext));
  assign occ_map  = occ;
  assign busy     = (state != IDLE);

  // Invalid counts are always eligible so they get rejected instead of starving.
  always_comb begin
    elig  = '0;
    cnt_r = '0;
    for (int unsigned r = 0; r < NREQ; r++) begin
      cnt_r   = bus.req_cnt[r*CNTW +: CNTW];
      elig[r] = bus.req_valid[r] &&
                ((cnt_r == '0) || (cnt_r > MAXCNT) || (cnt_r <= free_cnt));
    end
  end

  rr_pick #(.NREQ(NREQ), .RIDW(RIDW)) u_pick (
    .elig  (elig),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign pick_cnt = bus.req_cnt[pick_idx*CNTW +: CNTW];
  assign pick_err = (pick_cnt == '0) || (pick_cnt > MAXCNT);

  always_comb begin
    win   = occ[scan_idx +: SCANW];
    claim = '0;
    left  = remaining;
    for (int unsigned i = 0; i < SCANW; i++) begin
      if (!win[i] && (left != '0)) begin
        claim[i] = 1'b1;
        left     = left - 1'b1;
      end
    end
    claim_full = (state == SCAN) ? (NMULT'(claim) << scan_idx) : '0;
  end

  // Claimed-but-ungranted bits are shielded from release.
  assign rel_eff = bus.rel_valid ? (bus.rel_mask & ~pend) : '0;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state         <= IDLE;
      occ           <= '0;
      pend          <= '0;
      rr_ptr        <= '0;
      sel_id        <= '0;
      remaining     <= '0;
      scan_idx      <= '0;
      bus.gnt_valid <= 1'b0;
      bus.gnt_err   <= 1'b0;
      bus.gnt_id    <= '0;
      bus.gnt_mask  <= '0;
    end else begin
      occ <= (occ & ~rel_eff) | claim_full;
      case (state)
        IDLE: begin
          if (|bus.req_valid) state <= ARB;
        end
        ARB: begin
          if (pick_found) begin
            sel_id    <= pick_idx;
            remaining <= pick_cnt;
            scan_idx  <= '0;
            if (pick_err) begin
              state         <= GRANT;
              bus.gnt_valid <= 1'b1;
              bus.gnt_err   <= 1'b1;
              bus.gnt_id    <= pick_idx;
              bus.gnt_mask  <= '0;
            end else begin
              state <= SCAN;
            end
          end else begin
            state <= IDLE;
          end
        end
        SCAN: begin
          pend      <= pend | claim_full;
          remaining <= left;
          scan_idx  <= (scan_idx == LAST_IDX) ? '0 : scan_idx + IDXW'(SCANW);
          if (left == '0) begin
            state         <= GRANT;
            bus.gnt_valid <= 1'b1;
            bus.gnt_id    <= sel_id;
            bus.gnt_mask  <= pend | claim_full;
          end
        end
        GRANT: begin
          if (bus.gnt_ack) begin
            pend          <= '0;
            bus.gnt_valid <= 1'b0;
            bus.gnt_err   <= 1'b0;
            bus.gnt_mask  <= '0;
            rr_ptr        <= (sel_id == RIDW'(NREQ - 1)) ? '0 : sel_id + 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ARB only admits requests that fit, so the last window must finish the claim.
  a_scan_no_wrap: assert property (@(posedge clk) disable iff (!rstn)
    (state == SCAN && scan_idx == LAST_IDX) |-> (left == '0));

endmodule

// File: tb/tb_mult_pool_alloc.sv
// Bench for mult_pool_alloc: directed scenarios plus randomized traffic against
// a bitmap-level reference model.
module tb_mult_pool_alloc;

  localparam int NM = 64;
  localparam int NR = 4;
  localparam int CW = 7;

  logic        clk = 1'b0;
  logic        rstn;
  logic [63:0] occ_map;
  logic [6:0]  free_cnt;
  logic        busy;

  mult_pool_alloc_if #(.NMULT(64), .NREQ(4), .RIDW(2), .CNTW(7)) bus ();

  mult_pool_alloc #(.NMULT(64), .NREQ(4), .RIDW(2), .CNTW(7), .SCANW(8)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .bus      (bus),
    .occ_map  (occ_map),
    .free_cnt (free_cnt),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [63:0] model_occ;
  int          model_ptr;
  bit          mreq_v [NR];
  int          mreq_c [NR];

  int          last_id;
  logic [63:0] last_mask;
  bit          last_err;
  int          last_lat;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] lowest_free(input logic [63:0] o, input int n);
    logic [63:0] m;
    int left;
    m = '0;
    left = n;
    for (int i = 0; i < NM; i++) begin
      if (!o[i] && left > 0) begin
        m[i] = 1'b1;
        left--;
      end
    end
    return m;
  endfunction

  function automatic int model_pick();
    int r;
    int c;
    for (int k = 0; k < NR; k++) begin
      r = (model_ptr + k) % NR;
      c = mreq_c[r];
      if (mreq_v[r] && (c == 0 || c > NM || c <= NM - $countones(model_occ))) return r;
    end
    return -1;
  endfunction

  function automatic bit any_pending();
    for (int r = 0; r < NR; r++) if (mreq_v[r]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic set_req(input int r, input int cnt);
    mreq_v[r] = 1'b1;
    mreq_c[r] = cnt;
    bus.req_cnt[r*CW +: CW] = 7'(cnt);
    bus.req_valid[r] = 1'b1;
  endtask

  task automatic mrel(input logic [63:0] m);
    bus.rel_valid = 1'b1;
    bus.rel_mask  = m;
    tick();
    bus.rel_valid = 1'b0;
    bus.rel_mask  = '0;
    model_occ = model_occ & ~m;
  endtask

  task automatic expect_grant(input string tag);
    int          eid;
    int          c;
    bit          eerr;
    logic [63:0] emask;
    int          n;
    eid = model_pick();
    if (eid < 0) begin
      chk({tag, " model_has_candidate"}, 64'(0), 64'(1));
      return;
    end
    c     = mreq_c[eid];
    eerr  = (c == 0) || (c > NM);
    emask = eerr ? 64'h0 : lowest_free(model_occ, c);
    n = 0;
    while (bus.gnt_valid !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    last_lat = n;
    chk({tag, " gnt_valid"}, 64'(bus.gnt_valid), 64'(1));
    if (bus.gnt_valid !== 1'b1) return;
    last_id   = int'(bus.gnt_id);
    last_mask = bus.gnt_mask;
    last_err  = bus.gnt_err;
    chk({tag, " gnt_id"},   64'(bus.gnt_id),  64'(eid));
    chk({tag, " gnt_err"},  64'(bus.gnt_err), 64'(eerr));
    chk({tag, " gnt_mask"}, bus.gnt_mask,     emask);
    model_occ = model_occ | emask;
    chk({tag, " occ_map"},  occ_map,          model_occ);
    chk({tag, " free_cnt"}, 64'(free_cnt),    64'(NM - $countones(model_occ)));
    bus.gnt_ack = 1'b1;
    bus.req_valid[eid] = 1'b0;
    mreq_v[eid] = 1'b0;
    tick();
    bus.gnt_ack = 1'b0;
    model_ptr = (eid + 1) % NR;
    chk({tag, " gnt_valid_after_ack"}, 64'(bus.gnt_valid), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0, g1, g2, seen, p, sel, cnt;
    logic [63:0] rel;

    rstn = 1'b0;
    bus.req_valid = '0;
    bus.req_cnt   = '0;
    bus.gnt_ack   = 1'b0;
    bus.rel_valid = 1'b0;
    bus.rel_mask  = '0;
    model_occ = '0;
    model_ptr = 0;
    for (int r = 0; r < NR; r++) begin
      mreq_v[r] = 1'b0;
      mreq_c[r] = 0;
    end
    repeat (3) tick();
    chk("reset occ_map",   occ_map,               64'h0);
    chk("reset gnt_valid", 64'(bus.gnt_valid),    64'(0));
    chk("reset gnt_err",   64'(bus.gnt_err),      64'(0));
    chk("reset gnt_id",    64'(bus.gnt_id),       64'(0));
    chk("reset gnt_mask",  bus.gnt_mask,          64'h0);
    chk("reset free_cnt",  64'(free_cnt),         64'(64));
    chk("reset busy",      64'(busy),             64'(0));
    rstn = 1'b1;
    tick();

    // r0 asks for 5 from an empty pool
    set_req(0, 5);
    expect_grant("t1");
    chk("t1 latency", 64'(last_lat), 64'(3));
    chk("t1 mask",    last_mask,     64'h1F);
    chk("t1 free",    64'(free_cnt), 64'(59));
    mrel(64'h1F);

    // Build occ = ...FF0F, then r1 asks for 6
    set_req(0, 16);
    expect_grant("t2a");
    mrel(64'hF0);
    chk("t2 occ_setup", occ_map, 64'hFF0F);
    set_req(1, 6);
    expect_grant("t2");
    chk("t2 mask",    last_mask,     64'h300F0);
    chk("t2 latency", 64'(last_lat), 64'(5));
    mrel(model_occ);

    // Round-robin from rr_ptr=1 with r0, r2, r3 contending
    set_req(0, 1);
    expect_grant("t3a");
    mrel(model_occ);
    set_req(0, 10);
    set_req(2, 10);
    set_req(3, 10);
    expect_grant("t3 g0"); g0 = last_id;
    expect_grant("t3 g1"); g1 = last_id;
    expect_grant("t3 g2"); g2 = last_id;
    chk("t3 order0", 64'(g0), 64'(2));
    chk("t3 order1", 64'(g1), 64'(3));
    chk("t3 order2", 64'(g2), 64'(0));
    mrel(model_occ);
    set_req(0, 1);
    set_req(1, 1);
    expect_grant("t3 ptr");
    chk("t3 rr_ptr_is_1", 64'(last_id), 64'(1));
    expect_grant("t3 tail");
    mrel(model_occ);

    // Request that does not fit stays pending until a release
    set_req(1, 60);
    expect_grant("t4a");
    chk("t4 free4", 64'(free_cnt), 64'(4));
    set_req(0, 8);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.gnt_valid === 1'b1) seen++;
    end
    chk("t4 pending_no_grant", 64'(seen), 64'(0));
    mrel(64'h0F00);
    expect_grant("t4");
    chk("t4 mask", last_mask, 64'hF000_0000_0000_0F00);
    mrel(model_occ);

    // Rejections for count 0 and count 65
    set_req(1, 3);
    expect_grant("t5a");
    set_req(3, 0);
    expect_grant("t5 zero");
    chk("t5 zero err",     64'(last_err),  64'(1));
    chk("t5 zero mask",    last_mask,      64'h0);
    chk("t5 zero latency", 64'(last_lat),  64'(2));
    chk("t5 zero occ",     occ_map,        64'h7);
    set_req(3, 65);
    expect_grant("t5 big");
    chk("t5 big err",  64'(last_err), 64'(1));
    chk("t5 big mask", last_mask,     64'h0);
    chk("t5 big occ",  occ_map,       64'h7);
    mrel(model_occ);

    // Release aimed at claimed-but-ungranted bits during SCAN
    set_req(1, 20);
    repeat (3) tick();
    bus.rel_valid = 1'b1;
    bus.rel_mask  = 64'hFF;
    tick();
    bus.rel_valid = 1'b0;
    bus.rel_mask  = '0;
    expect_grant("t6");
    chk("t6 mask", last_mask, 64'hFFFFF);
    mrel(model_occ);

    // Randomized traffic
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 2) == 0 && model_occ != 0) begin
        rel = model_occ & {$urandom, $urandom};
        mrel(rel);
      end else begin
        tick();
      end
      for (int r = 0; r < NR; r++) begin
        if (!mreq_v[r] && $urandom_range(0, 1) == 1) begin
          sel = int'($urandom_range(0, 9));
          if (sel == 0)      cnt = 0;
          else if (sel == 1) cnt = int'($urandom_range(65, 127));
          else               cnt = int'($urandom_range(1, 24));
          set_req(r, cnt);
        end
      end
      tick();
      p = model_pick();
      if (p < 0 && any_pending()) begin
        mrel(model_occ);
        p = model_pick();
      end
      if (p >= 0) expect_grant($sformatf("rand%0d", it));
    end
    for (int d = 0; d < 20 && any_pending(); d++) begin
      if (model_pick() < 0) mrel(model_occ);
      expect_grant($sformatf("drain%0d", d));
    end

    // Reset while a claim is in progress
    mrel(model_occ);
    set_req(2, 16);
    repeat (3) tick();
    rstn = 1'b0;
    bus.req_valid = '0;
    tick();
    chk("t7 reset occ",       occ_map,            64'h0);
    chk("t7 reset gnt_valid", 64'(bus.gnt_valid), 64'(0));
    chk("t7 reset free",      64'(free_cnt),      64'(64));
    rstn = 1'b1;
    model_occ = '0;
    model_ptr = 0;
    for (int r = 0; r < NR; r++) mreq_v[r] = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.gnt_valid === 1'b1) seen++;
    end
    chk("t7 no_grant", 64'(seen), 64'(0));
    chk("t7 idle",     64'(busy), 64'(0));
    set_req(0, 3);
    expect_grant("t7 post");
    chk("t7 post mask", last_mask, 64'h7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
